knight_rider_sequencer: RTL

Controller for the Knight Rider LED flasher. It converts a slow single-cycle tick from the clock-divider chain into a bouncing light position across the 10 red LEDs, with on/off toggling from a push button and selectable scan speed. It sits between the divider chain (tick source) and the LEDR pins. It replaces the ad-hoc up/down counter plus toggle latch with one synchronous state machine.

---
 rtl/knight_rider_sequencer_if.sv | 26 ++
 rtl/knight_rider_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/knight_rider_sequencer_if.sv
// Signal bundle between the tick/button side and the Knight Rider sequencer.
// TICK is a one-cycle strobe with no back-pressure. Each outputs is a register in the sequencer.
interface knight_rider_sequencer_if #(
  parameter int N_LEDS = 10,
  parameter int POS_W  = 4
);
  logic              ONOFF;
  logic              TICK;
  logic [1:0]        SPEED;
  logic              TAIL;
  logic [N_LEDS-1:0] LEDR;
  logic [POS_W-1:0]  POS;
  logic              DIR;
  logic              RUN;
  logic [1:0]        STATE;

  modport master (
    output ONOFF, TICK, SPEED, TAIL,
    input  LEDR, POS, DIR, RUN, STATE
  );

  modport slave (
    input  ONOFF, TICK, SPEED, TAIL,
    output LEDR, POS, DIR, RUN, STATE
  );
endinterface

// File: rtl/knight_rider_sequencer.sv
// Bouncing-light sequencer: button toggles scanning, divided TICKs step a
// position back and forth across N_LEDS, every output registered.
module knight_rider_sequencer #(
  parameter int N_LEDS = 10,
  parameter int POS_W  = 4
) (
  input  logic                     CLK,
  input  logic                     CLEAR,
  knight_rider_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DN   = 2'd2;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_PEN  = POS_W'(N_LEDS - 2);

  logic              on_meta_q, on_sync_q, on_prev_q;
  logic              meta_real_q, armed_q;
  logic [1:0]        state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  prev_q, prev_d;
  logic              dir_q, dir_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              run_q;
  logic              press, scanning, step;
  logic [3:0]        limit;

  // Synchronizer flops reset high. The edge detector only arms after a real
  // high sample, so a button held through reset release is not a press.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      on_meta_q   <= 1'b1;
      on_sync_q   <= 1'b1;
      on_prev_q   <= 1'b1;
      meta_real_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      on_meta_q   <= bus.ONOFF;
      on_sync_q   <= on_meta_q;
      on_prev_q   <= on_sync_q;
      meta_real_q <= 1'b1;
      armed_q     <= armed_q | (meta_real_q & on_meta_q);
    end
  end

  assign press    = armed_q & on_prev_q & ~on_sync_q;
  assign scanning = (state_q != ST_IDLE);
  assign limit    = (4'd1 << bus.SPEED) - 4'd1;
  assign step     = scanning & bus.TICK & ({1'b0, cnt_q} >= limit);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    prev_d  = prev_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    led_d   = '0;
    if (press) begin
      cnt_d = '0;
      if (!scanning) begin
        state_d = ST_UP;
        pos_d   = '0;
        prev_d  = '0;
        dir_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (!scanning) begin
      cnt_d = '0;
    end else begin
      if (bus.TICK) cnt_d = step ? 3'd0 : cnt_q + 3'd1;
      if (step) begin
        prev_d = pos_q;
        case (state_q)
          ST_UP: begin
            if (pos_q == POS_LAST) begin
              state_d = ST_DN;
              pos_d   = POS_PEN;
              dir_d   = 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
          ST_DN: begin
            if (pos_q == '0) begin
              state_d = ST_UP;
              pos_d   = POS_W'(1);
              dir_d   = 1'b0;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
    // Pattern is built from next-state values so LEDR lines up with POS.
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < N_LEDS; i++) begin
        led_d[i] = (pos_d == POS_W'(i)) |
                   (bus.TAIL & (prev_d != pos_d) & (prev_d == POS_W'(i)));
      end
    end
  end

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      prev_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      led_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      prev_q  <= prev_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      run_q   <= (state_d != ST_IDLE);
    end
  end

  assign bus.LEDR  = led_q;
  assign bus.POS   = pos_q;
  assign bus.DIR   = dir_q;
  assign bus.RUN   = run_q;
  assign bus.STATE = state_q;

endmodule
